// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmit scheduler and its LRCLK front end.
package i2s_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ARB  = 2'd2,
        S_LOAD = 2'd3
    } sched_state_t;

    localparam int DEF_DW = 16;

    // Index width that never collapses to zero bits for tiny source counts.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_lrclk_sync.sv
// Brings LRCLK into the clk domain and emits a one-cycle frame_start on its
// falling edge, three clk after the fall. Also usable on the receive side.
module i2s_lrclk_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic lrclk,
    output logic frame_start
);

    // [0],[1] are the synchronizer; [2] holds the previous synchronized level.
    logic [2:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= '0;
            frame_start <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[1:0], lrclk};
            frame_start <= sync_reg[2] & ~sync_reg[1];
        end
    end

endmodule

// File: rtl/i2s_tx_sched.sv
// Frame-synchronous round-robin scheduler feeding one I2S transmitter from
// NUM_SRC stereo sources. Define HOLD_LAST_EN to hold the last sample on underrun.
module i2s_tx_sched
    import i2s_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int DW             = DEF_DW,
    parameter int UNDERRUN_LIMIT = 4,
    localparam int IW            = idx_width(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  audio_lrclk,
    input  logic [NUM_SRC-1:0]    src_valid,
    output logic [NUM_SRC-1:0]    src_ready,
    input  logic [NUM_SRC*DW-1:0] src_ldata,
    input  logic [NUM_SRC*DW-1:0] src_rdata,
    output logic [DW-1:0]         audio_ldata,
    output logic [DW-1:0]         audio_rdata,
    output logic                  grant_valid,
    output logic [IW-1:0]         grant_id,
    output logic                  underrun,
    output logic [15:0]           underrun_cnt
);

    sched_state_t  state_reg, state_next;
    logic          frame_start;
    logic [7:0]    miss_cnt_reg;
    logic [7:0]    miss_inc;
    logic          arb_hit;
    logic [IW-1:0] arb_id;
    logic          owner_valid;
    logic [DW-1:0] ldata_arr [NUM_SRC];
    logic [DW-1:0] rdata_arr [NUM_SRC];

    i2s_lrclk_sync u_lrclk_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .lrclk       (audio_lrclk),
        .frame_start (frame_start)
    );

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign ldata_arr[gi] = src_ldata[gi*DW +: DW];
        assign rdata_arr[gi] = src_rdata[gi*DW +: DW];
    end

    assign owner_valid = src_valid[grant_id];
    assign miss_inc    = miss_cnt_reg + 8'd1;

    // Scan offsets from the far end so the nearest valid source after grant_id wins.
    always_comb begin
        arb_hit = 1'b0;
        arb_id  = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            if (src_valid[(int'(grant_id) + i) % NUM_SRC]) begin
                arb_hit = 1'b1;
                arb_id  = IW'((int'(grant_id) + i) % NUM_SRC);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (enable) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (frame_start) begin
                    if (!enable)         state_next = S_IDLE;
                    else if (grant_valid) state_next = S_LOAD;
                    else                  state_next = S_ARB;
                end
            end
            S_ARB:   state_next = arb_hit ? S_LOAD : S_WAIT;
            S_LOAD:  state_next = S_WAIT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        src_ready = '0;
        underrun  = 1'b0;
        if (state_reg == S_LOAD) begin
            src_ready[grant_id] = 1'b1;
            underrun            = ~owner_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_ldata  <= '0;
            audio_rdata  <= '0;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            underrun_cnt <= '0;
            miss_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_WAIT: begin
                    if (frame_start && !enable) begin
                        audio_ldata <= '0;
                        audio_rdata <= '0;
                        grant_valid <= 1'b0;
                    end
                end
                S_ARB: begin
                    if (arb_hit) begin
                        grant_id     <= arb_id;
                        grant_valid  <= 1'b1;
                        miss_cnt_reg <= '0;
                    end else begin
                        audio_ldata <= '0;
                        audio_rdata <= '0;
                    end
                end
                S_LOAD: begin
                    if (owner_valid) begin
                        audio_ldata  <= ldata_arr[grant_id];
                        audio_rdata  <= rdata_arr[grant_id];
                        miss_cnt_reg <= '0;
                    end else begin
                        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
`ifdef HOLD_LAST_EN
`else
                        audio_ldata <= '0;
                        audio_rdata <= '0;
`endif
                        miss_cnt_reg <= miss_inc;
                        // Releasing here lets the very next frame re-arbitrate.
                        if (miss_inc == 8'(UNDERRUN_LIMIT)) grant_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Randomized scoreboard bench for i2s_tx_sched: a frame-level reference model
// predicts each frame's outcome, a separate monitor compares the DUT to it.
module tb_i2s_tx_sched;

    localparam int NUM_SRC = 3;
    localparam int DW      = 16;
    localparam int LIMIT   = 4;
    localparam int IW      = $clog2(NUM_SRC);
    localparam int FRAMES  = 220;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic                  audio_lrclk;
    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC-1:0]    src_ready;
    logic [NUM_SRC*DW-1:0] src_ldata;
    logic [NUM_SRC*DW-1:0] src_rdata;
    logic [DW-1:0]         audio_ldata;
    logic [DW-1:0]         audio_rdata;
    logic                  grant_valid;
    logic [IW-1:0]         grant_id;
    logic                  underrun;
    logic [15:0]           underrun_cnt;

    always #5 clk = ~clk;

    i2s_tx_sched #(
        .NUM_SRC        (NUM_SRC),
        .DW             (DW),
        .UNDERRUN_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .audio_lrclk  (audio_lrclk),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_ldata    (src_ldata),
        .src_rdata    (src_rdata),
        .audio_ldata  (audio_ldata),
        .audio_rdata  (audio_rdata),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    typedef struct {
        logic [NUM_SRC-1:0] ready;
        int                 und;
        logic [DW-1:0]      l;
        logic [DW-1:0]      r;
        logic               gv;
        logic [IW-1:0]      gid;
        logic [15:0]        cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b1;

    // Reference model state, tracked per frame.
    bit            m_running;
    bit            m_gv;
    int            m_gid;
    int            m_miss;
    logic [15:0]   m_cnt;
    logic [DW-1:0] m_l, m_r;

    bit            refill [NUM_SRC];
    bit            fixed_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic put_src(input int i, input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
        src_valid[i]          = v;
        src_ldata[i*DW +: DW] = l;
        src_rdata[i*DW +: DW] = r;
    endtask

    task automatic model_reset();
        m_running = 0; m_gv = 0; m_gid = 0; m_miss = 0;
        m_cnt = '0; m_l = '0; m_r = '0;
        exp_q.delete();
    endtask

    // One frame of the scheduling rules, evaluated at the LRCLK fall.
    task automatic model_frame();
        exp_t e;
        bit   load;
        e.ready = '0;
        e.und   = 0;
        if (m_running || enable) begin
            if (!enable) begin
                m_running = 0; m_gv = 0; m_l = '0; m_r = '0;
            end else begin
                m_running = 1;
                load = m_gv;
                if (!m_gv) begin
                    for (int k = 1; k <= NUM_SRC; k++) begin
                        if (src_valid[(m_gid + k) % NUM_SRC]) begin
                            m_gid = (m_gid + k) % NUM_SRC;
                            m_gv = 1; m_miss = 0; load = 1;
                            break;
                        end
                    end
                    if (!load) begin m_l = '0; m_r = '0; end
                end
                if (load) begin
                    e.ready[m_gid] = 1'b1;
                    if (src_valid[m_gid]) begin
                        m_l = src_ldata[m_gid*DW +: DW];
                        m_r = src_rdata[m_gid*DW +: DW];
                        m_miss = 0;
                    end else begin
                        e.und = 1;
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`ifndef HOLD_LAST_EN
                        m_l = '0; m_r = '0;
`endif
                        m_miss++;
                        if (m_miss == LIMIT) m_gv = 0;
                    end
                end
            end
        end
        e.l = m_l; e.r = m_r; e.gv = m_gv; e.gid = IW'(m_gid); e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic mid_stim(input int f);
        if (f == 2) begin
            put_src(0, 1'b1, 16'h1234, 16'hABCD);
            refill[0] = 1; fixed_data = 1;
        end else if (f == 10) begin
            refill[1] = 0;
        end else if (f == 20) begin
            enable = 1'b0;
        end else if (f == 22) begin
            enable = 1'b1;
        end else if (f >= 24) begin
            enable = ($urandom_range(9) != 0);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!src_valid[i] && $urandom_range(2) == 0)
                    put_src(i, 1'b1, DW'($urandom), DW'($urandom));
                refill[i] = ($urandom_range(1) == 1);
            end
        end
    endtask

    task automatic run_frame(input int f, input bit do_reset);
        logic [NUM_SRC-1:0] xfer;
        bit done = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            xfer = src_valid & src_ready;
            if (do_reset && !done && k >= 3 && src_ready != '0) begin
                rst_n = 1'b0;
                #1;
                check("rst_audio_l", 32'(audio_ldata), 32'h0);
                check("rst_audio_r", 32'(audio_rdata), 32'h0);
                check("rst_grant_valid", 32'(grant_valid), 32'h0);
                check("rst_grant_id", 32'(grant_id), 32'h0);
                check("rst_src_ready", 32'(src_ready), 32'h0);
                check("rst_underrun_cnt", 32'(underrun_cnt), 32'h0);
                done = 1;
                xfer = '0;
                model_reset();
                put_src(1, 1'b1, DW'($urandom), DW'($urandom));
                refill[1] = 1; fixed_data = 0;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (xfer[i]) begin
                    if (!refill[i])                put_src(i, 1'b0, '0, '0);
                    else if (fixed_data && i == 0) put_src(i, 1'b1, 16'h1234, 16'hABCD);
                    else                           put_src(i, 1'b1, DW'($urandom), DW'($urandom));
                end
            end
            if (k == 0) begin
                if (do_reset) mon_en = 1'b0;
                audio_lrclk = 1'b0;
                if (!do_reset) model_frame();
            end
            if (k == 16) begin
                audio_lrclk = 1'b1;
                mid_stim(f);
            end
            if (do_reset && k == 20) begin
                if (!done) check("rst_load_window_seen", 32'h0, 32'h1);
                rst_n = 1'b1;
            end
        end
        if (do_reset) mon_en = 1'b1;
    endtask

    // Monitor: watches each frame's decision window and scores it.
    initial begin : monitor
        logic [DW-1:0]      prev_l = '0;
        logic [DW-1:0]      prev_r = '0;
        logic [NUM_SRC-1:0] seen;
        int                 pulses;
        exp_t               e;
        forever begin
            @(negedge audio_lrclk);
            if (!mon_en) begin
                prev_l = '0; prev_r = '0;
                continue;
            end
            seen = '0; pulses = 0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (k <= 3) begin
                    check("stable_l", 32'(audio_ldata), 32'(prev_l));
                    check("stable_r", 32'(audio_rdata), 32'(prev_r));
                end
                seen   |= src_ready;
                pulses += int'(underrun);
            end
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'h0, 32'h1);
            end else begin
                e = exp_q.pop_front();
                check("src_ready_mask", 32'(seen), 32'(e.ready));
                check("underrun_pulses", 32'(pulses), 32'(e.und));
                check("audio_l", 32'(audio_ldata), 32'(e.l));
                check("audio_r", 32'(audio_rdata), 32'(e.r));
                check("grant_valid", 32'(grant_valid), 32'(e.gv));
                if (e.gv) check("grant_id", 32'(grant_id), 32'(e.gid));
                check("underrun_cnt", 32'(underrun_cnt), 32'(e.cnt));
                prev_l = e.l; prev_r = e.r;
            end
        end
    end

    initial begin : stimulus
        rst_n       = 1'b0;
        enable      = 1'b1;
        audio_lrclk = 1'b1;
        src_valid   = '0;
        src_ldata   = '0;
        src_rdata   = '0;
        fixed_data  = 0;
        for (int i = 0; i < NUM_SRC; i++) refill[i] = 0;
        model_reset();
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int f = 0; f < FRAMES; f++) run_frame(f, f == 7);
        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_tx_sched.md
Name: i2s_tx_sched

Overview:
Frame-synchronous scheduler that shares the I2S transmitter between NUM_SRC stereo sample sources. It owns the transmitter's audio_ldata/audio_rdata inputs and tracks audio_lrclk to find frame boundaries. Each frame it loads one stereo sample from the current owner, or arbitrates ownership round-robin. A sticky owner keeps the transmitter until it misses UNDERRUN_LIMIT consecutive frames.

Parameters:
NUM_SRC, 2, number of requesting sources (2..8)
DW, 16, sample width per channel
UNDERRUN_LIMIT, 4, consecutive missed frames before the owner's grant is released (1..255)

Ports:
clk  in  1  system clock, same domain as the I2S transmitter
rst_n  in  1  asynchronous active-low reset
enable  in  1  scheduler enable, level
audio_lrclk  in  1  LRCLK from the transmitter; low = left half, falling edge = frame start
src_valid  in  NUM_SRC  per-source sample available
src_ready  out  NUM_SRC  per-source one-cycle consume strobe
src_ldata  in  NUM_SRC*DW  left samples, source i at [i*DW +: DW]
src_rdata  in  NUM_SRC*DW  right samples, same packing
audio_ldata  out  DW  left sample to the transmitter
audio_rdata  out  DW  right sample to the transmitter
grant_valid  out  1  an owner is held
grant_id  out  clog2(NUM_SRC)  current or last owner
underrun  out  1  one-cycle pulse per missed owner frame
underrun_cnt  out  16  saturating count of underruns

Behaviour:
- Reset values (asynchronous): all outputs 0. Internal state: S_IDLE, miss_cnt=0, sync flops=0.
- LRCLK handling: 2-flop synchronizer, then a falling-edge detect. frame_start pulses one cycle, 3 clk after the lrclk fall.
- Timing: the transmitter latches its data at frame start. Scheduler outputs change only 2–3 clk after frame_start, so a loaded sample plays in the next frame. Outputs are otherwise stable.
- clk must exceed 8× the frame rate. frame_start is ignored outside S_WAIT.
- S_IDLE: outputs held at 0, no src_ready. When enable=1, go to S_WAIT.
- S_WAIT: on frame_start:
  - enable=0: audio outputs <= 0, grant_valid <= 0, go to S_IDLE.
  - enable=1 and grant_valid=1: go to S_LOAD.
  - enable=1 and grant_valid=0: go to S_ARB.
- S_ARB (1 cycle): search src_valid round-robin, starting at (grant_id+1) mod NUM_SRC.
  - Hit: grant_id <= hit, grant_valid <= 1, miss_cnt <= 0, go to S_LOAD.
  - No hit: audio outputs <= 0, go to S_WAIT.
- S_LOAD (1 cycle): src_ready[grant_id]=1 this cycle only.
  - src_valid[grant_id]=1: audio_ldata/rdata <= that source's data, miss_cnt <= 0.
  - src_valid[grant_id]=0: underrun pulse; underrun_cnt += 1, saturating at 0xFFFF; audio outputs <= 0; miss_cnt += 1. If the new miss_cnt equals UNDERRUN_LIMIT, grant_valid <= 0 and the next frame re-arbitrates.
  - Go to S_WAIT.
- Handshake: a transfer is src_valid & src_ready in the same cycle. Sources hold valid and data stable until that transfer. src_ready is never asserted to a non-owner.
- Simultaneous requests: only the round-robin winner is granted; losers wait for release.
- Owner drops valid for fewer than UNDERRUN_LIMIT frames: it keeps the grant; each missed frame outputs zero and counts one underrun.
- enable deasserted mid-stream: takes effect at the next frame_start; the current frame's sample is still played.
- underrun_cnt is cleared only by reset.

Optional Feature:
HOLD_LAST_EN. Defined: on an underrun, audio outputs keep the last delivered sample instead of 0. Zeroing on S_ARB-no-hit and on enable=0 is unchanged. Undefined: underrun outputs 0.

Decomposition:
- Package i2s_pkg: state encoding (S_IDLE, S_WAIT, S_ARB, S_LOAD), the DW default, and an index-width function.
- Sub-module i2s_lrclk_sync: 2-flop synchronizer plus falling-edge detect, output frame_start. It is reusable by the receive side.

Test Plan:
- Reset released with enable=1, no src_valid, 3 frames -> audio outputs stay 0, grant_valid=0, no src_ready.
- Source 0 valid with L=0x1234 R=0xABCD -> grant_id=0; src_ready[0] pulses once per frame; outputs 0x1234/0xABCD within 5 clk of frame_start.
- Both sources valid from reset -> source 1 is granted first (start index = 0+1). Source 0 is never readied while source 1 stays valid.
- Owner 1 drops valid for 4 frames -> 4 underrun pulses, underrun_cnt=4, outputs 0. Grant released after the 4th miss; next frame grants source 0 if it is valid.
- With HOLD_LAST_EN, owner delivers 0x5555/0x6666 then misses 2 frames -> outputs stay 0x5555/0x6666, underrun_cnt=2, grant held.
- rst_n asserted mid-S_LOAD and enable toggled 0 mid-frame -> immediate all-zero outputs on reset; for the enable toggle, zero outputs and S_IDLE only after the next frame_start.
